lsu_rmw: RTL and testbench

- Multicycle load/store unit downstream of the A/B operand registers and upstream of the 64-bit data memory (Memoria64).
- Takes one RISC-V load or store request: byte, half, word or doubleword, with an address already computed by the ALU.
- Loads: reads the aligned doubleword, then extracts and sign- or zero-extends the addressed field.
- Sub-doubleword stores: does a read-modify-write, because the memory only writes whole doublewords. The control unit waits for done before advancing.

---
 rtl/lsu_rmw.sv | 225 ++++++++++++++++++++++
 tb/tb_lsu_rmw.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// lsu_rmw: multicycle RISC-V load/store unit in front of a 64-bit,
// doubleword-only data memory. Loads read the aligned doubleword and then
// extract and extend the addressed field. Sub-doubleword stores do a
// read-modify-write. sd writes directly.
//
// Optional feature: define LSU_DWORD_BUFFER_EN to add a one-entry
// doubleword buffer that lets repeat accesses skip the memory read.
//
// Parameters:
//   MEM_LAT    cycles from mem_raddr to valid mem_rdata (1..4)
//   AW         address width
// Ports:
//   Clk, Reset            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_funct3            RISC-V size/sign code
//   req_addr, req_wdata   byte address and store data (low bytes used)
//   done                  one-cycle completion pulse
//   load_data             extended load result, held between loads
//   misaligned, illegal   fault flags, valid with done
//   mem_raddr/mem_waddr   doubleword-aligned memory addresses
//   mem_wdata, mem_wr     merged write data and write enable
//   mem_rdata             memory read data
//
// state   | meaning
// IDLE    | ready for a request
// RD_WAIT | waiting MEM_LAT cycles for the doubleword read
// WRITE   | one-cycle doubleword write
// DONE    | done pulse, flags valid
module lsu_rmw #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 64
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [63:0]   req_wdata,
  output logic          done,
  output logic [63:0]   load_data,
  output logic          misaligned,
  output logic          illegal,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [63:0]   mem_wdata,
  output logic          mem_wr,
  input  logic [63:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic          r_we;
  logic [2:0]    r_funct3;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;
  logic          r_mis;
  logic          r_ill;
  logic [2:0]    cnt;
  logic [63:0]   wr_data;

  logic          accept;
  logic          req_ill;
  logic          req_mis;
  logic          req_fault;
  logic          req_sd;
  logic          req_hit;
  logic [63:0]   hit_data;
  logic          rd_last;

  // Field extraction: shift the addressed byte to lane 0, then extend.
  function automatic logic [63:0] extract(input logic [63:0] d,
                                          input logic [2:0]  off,
                                          input logic [2:0]  f3);
    logic [63:0] s;
    logic [63:0] res;
    s = d >> {off, 3'b000};
    case (f3[1:0])
      2'd0:    res = f3[2] ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'd1:    res = f3[2] ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    res = f3[2] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: res = s;
    endcase
    return res;
  endfunction

  // Replace byte lanes [off +: size] of base with the low bytes of wd.
  function automatic logic [63:0] merge(input logic [63:0] base,
                                        input logic [63:0] wd,
                                        input logic [2:0]  off,
                                        input logic [1:0]  size);
    logic [63:0] mask;
    case (size)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    return (base & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

  always_comb begin
    req_ill = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    case (req_funct3[1:0])
      2'd1:    req_mis = req_addr[0];
      2'd2:    req_mis = |req_addr[1:0];
      2'd3:    req_mis = |req_addr[2:0];
      default: req_mis = 1'b0;
    endcase
    req_mis   = req_mis & ~req_ill;
    req_fault = req_ill | req_mis;
    req_sd    = req_we & (req_funct3 == 3'b011);
  end

`ifdef LSU_DWORD_BUFFER_EN
  logic          buf_valid;
  logic [AW-4:0] buf_tag;
  logic [63:0]   buf_data;

  assign req_hit  = buf_valid & (buf_tag == req_addr[AW-1:3]);
  assign hit_data = buf_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == RD_WAIT && rd_last) begin
      buf_valid <= 1'b1;
      buf_tag   <= r_addr[AW-1:3];
      buf_data  <= mem_rdata;
    end else if (state == WRITE) begin
      buf_valid <= 1'b1;
      buf_tag   <= r_addr[AW-1:3];
      buf_data  <= wr_data;
    end
  end
`else
  assign req_hit  = 1'b0;
  assign hit_data = 64'd0;
`endif

  assign accept  = req_valid & (state == IDLE);
  assign rd_last = (cnt == 3'd0);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault)    state_nxt = DONE;
          else if (req_sd)  state_nxt = WRITE;
          else if (req_hit) state_nxt = req_we ? WRITE : DONE;
          else              state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: if (rd_last) state_nxt = r_we ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    done       = (state == DONE);
    misaligned = (state == DONE) & r_mis;
    illegal    = (state == DONE) & r_ill;
    // Gated with Reset so a WRITE cycle that meets Reset never reaches memory.
    mem_wr     = (state == WRITE) & ~Reset;
  end

  assign mem_raddr = (state == IDLE) ? {req_addr[AW-1:3], 3'b000} : {r_addr[AW-1:3], 3'b000};
  assign mem_waddr = mem_raddr;
  assign mem_wdata = wr_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mis     <= 1'b0;
      r_ill     <= 1'b0;
      cnt       <= 3'd0;
      wr_data   <= '0;
      load_data <= '0;
    end else begin
      if (accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_mis    <= req_mis;
        r_ill    <= req_ill;
        cnt      <= 3'(MEM_LAT - 1);
        if (!req_fault) begin
          if (req_sd)
            wr_data <= req_wdata;
          else if (req_hit && req_we)
            wr_data <= merge(hit_data, req_wdata, req_addr[2:0], req_funct3[1:0]);
          else if (req_hit)
            load_data <= extract(hit_data, req_addr[2:0], req_funct3);
        end
      end else if (state == RD_WAIT) begin
        if (rd_last) begin
          if (r_we) wr_data   <= merge(mem_rdata, r_wdata, r_addr[2:0], r_funct3[1:0]);
          else      load_data <= extract(mem_rdata, r_addr[2:0], r_funct3);
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;
  localparam int MEM_LAT = 1;
  localparam int AW      = 64;
`ifdef LSU_DWORD_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  // Latencies for accesses that may hit the buffer.
  localparam int LD_H  = BUF ? 1 : MEM_LAT + 1;
  localparam int ST_HD = BUF ? 2 : MEM_LAT + 2;
  localparam int ST_HW = BUF ? 1 : MEM_LAT + 1;
  localparam int LD_M  = MEM_LAT + 1;
  localparam int ST_MD = MEM_LAT + 2;
  localparam int ST_MW = MEM_LAT + 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          done, misaligned, illegal, mem_wr;
  logic [63:0]   load_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;

  lsu_rmw #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .load_data(load_data),
    .misaligned(misaligned), .illegal(illegal), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Memory model: 512 doublewords, MEM_LAT-stage read pipeline.
  logic [63:0] mem [0:511];
  logic [63:0] pipe [MEM_LAT];
  always @(posedge Clk) begin
    if (mem_wr) mem[mem_waddr[11:3]] <= mem_wdata;
    pipe[0] <= mem[mem_raddr[11:3]];
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  typedef struct {int t; int lat; logic [63:0] ld; logic mis; logic ill;} done_exp_t;
  typedef struct {int t; int lat; logic [63:0] addr; logic [63:0] data;} wr_exp_t;
  done_exp_t sq[$];
  wr_exp_t   wq[$];

  int checks = 0;
  int failures = 0;
  logic [63:0] last_ld = 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (done) begin
        if (sq.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          done_exp_t e;
          e = sq.pop_front();
          chk("done_latency", 64'(cyc + 1 - e.t), 64'(e.lat));
          chk("load_data",    load_data,          e.ld);
          chk("misaligned",   64'(misaligned),    64'(e.mis));
          chk("illegal",      64'(illegal),       64'(e.ill));
        end
      end
      if (mem_wr) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_wr_unexpected actual=1 expected=0 addr=%h (cycle %0d)", mem_waddr, cyc);
        end else begin
          wr_exp_t w;
          w = wq.pop_front();
          chk("wr_latency", 64'(cyc + 1 - w.t), 64'(w.lat));
          chk("mem_waddr",  mem_waddr,          w.addr);
          chk("mem_wdata",  mem_wdata,          w.data);
        end
      end
    end
  end

  // Called at posedge+2 with the DUT idle; returns at posedge+2 once idle again.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input int lat, input logic mis,
                       input logic ill, input logic [63:0] ld_exp,
                       input bit has_wr, input int wlat, input logic [63:0] wdata_exp);
    done_exp_t e;
    wr_exp_t   w;
    int n;
    if (!we && !mis && !ill) last_ld = ld_exp;
    e.t = cyc + 1; e.lat = lat; e.ld = last_ld; e.mis = mis; e.ill = ill;
    sq.push_back(e);
    if (has_wr) begin
      w.t = cyc + 1; w.lat = wlat; w.addr = {addr[63:3], 3'b000}; w.data = wdata_exp;
      wq.push_back(w);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge Clk); #2;
    req_valid = 1'b0;
    n = 0;
    while ((sq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(posedge Clk); n++;
    end
    #2;
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL timeout actual=pending expected=done addr=%h", addr);
      sq.delete(); wq.delete();
    end
  endtask

  task automatic ld(input logic [2:0] f3, input logic [63:0] a, input int lat, input logic [63:0] v);
    issue(1'b0, f3, a, 64'd0, lat, 1'b0, 1'b0, v, 1'b0, 0, 64'd0);
  endtask

  task automatic st(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                    input int lat, input int wlat, input logic [63:0] merged);
    issue(1'b1, f3, a, wd, lat, 1'b0, 1'b0, 64'd0, 1'b1, wlat, merged);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'd0;
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = 64'd0;
    mem[9'h100 >> 3] = 64'h8877_6655_4433_2211;
    mem[9'h180 >> 3] = 64'h1122_3344_5566_7788;
    mem[10'h300 >> 3] = 64'h8000_0001_1111_1111;
    mem[11'h400 >> 3] = 64'h0123_4567_89AB_CDEF;
    Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_done",       64'(done),       64'd0);
    chk("rst_load_data",  load_data,       64'd0);
    chk("rst_mem_wr",     64'(mem_wr),     64'd0);
    chk("rst_misaligned", 64'(misaligned), 64'd0);
    chk("rst_illegal",    64'(illegal),    64'd0);
    @(posedge Clk); #2;

    // Loads from 0x100
    ld(3'b000, 64'h107, LD_M, 64'hFFFF_FFFF_FFFF_FF88);
    ld(3'b100, 64'h107, LD_H, 64'h0000_0000_0000_0088);
    ld(3'b001, 64'h106, LD_H, 64'hFFFF_FFFF_FFFF_8877);
    ld(3'b110, 64'h104, LD_H, 64'h0000_0000_8877_6655);

    // Read-modify-write stores at 0x180
    st(3'b001, 64'h182, 64'hFFFF_FFFF_FFFF_ABCD, ST_MD, ST_MW, 64'h1122_3344_ABCD_7788);
    ld(3'b001, 64'h182, LD_H, 64'hFFFF_FFFF_FFFF_ABCD);
    st(3'b010, 64'h184, 64'h0000_0000_1234_5678, ST_HD, ST_HW, 64'h1234_5678_ABCD_7788);
    ld(3'b010, 64'h180, LD_H, 64'hFFFF_FFFF_ABCD_7788);
    ld(3'b010, 64'h184, LD_H, 64'h0000_0000_1234_5678);
    st(3'b000, 64'h181, 64'h0000_0000_0000_005A, ST_HD, ST_HW, 64'h1234_5678_ABCD_5A88);
    ld(3'b011, 64'h180, LD_H, 64'h1234_5678_ABCD_5A88);

    // sd skips the read, then read back
    st(3'b011, 64'h208, 64'hDEAD_BEEF_CAFE_F00D, 2, 1, 64'hDEAD_BEEF_CAFE_F00D);
    ld(3'b011, 64'h208, LD_H, 64'hDEAD_BEEF_CAFE_F00D);

    // Faults: done at T+1, no memory write, load_data held
    issue(1'b0, 3'b010, 64'h102, 64'd0, 1, 1'b1, 1'b0, 64'd0, 1'b0, 0, 64'd0);
    issue(1'b0, 3'b111, 64'h100, 64'd0, 1, 1'b0, 1'b1, 64'd0, 1'b0, 0, 64'd0);
    issue(1'b1, 3'b100, 64'h100, 64'h55, 1, 1'b0, 1'b1, 64'd0, 1'b0, 0, 64'd0);
    issue(1'b1, 3'b011, 64'h20C, 64'h55, 1, 1'b1, 1'b0, 64'd0, 1'b0, 0, 64'd0);
    issue(1'b1, 3'b001, 64'h183, 64'h55, 1, 1'b1, 1'b0, 64'd0, 1'b0, 0, 64'd0);
    chk("mem_180_after_faults", mem[9'h180 >> 3], 64'h1234_5678_ABCD_5A88);

    // Same-dword reuse
    ld(3'b011, 64'h300, LD_M, 64'h8000_0001_1111_1111);
    ld(3'b010, 64'h304, LD_H, 64'hFFFF_FFFF_8000_0001);

    // Reset during the WRITE cycle of an sb
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 64'h400; req_wdata = 64'hFF;
    @(posedge Clk); #2 req_valid = 1'b0;
    repeat (MEM_LAT) @(posedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    chk("rst_write_mem_wr", 64'(mem_wr), 64'd0);
    @(posedge Clk); #2 Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_done",      64'(done),      64'd0);
    chk("post_rst_mem_400",   mem[11'h400 >> 3], 64'h0123_4567_89AB_CDEF);
    last_ld = 64'd0;
    @(posedge Clk); #2;
    ld(3'b000, 64'h400, LD_M, 64'hFFFF_FFFF_FFFF_FFEF);

    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
